// File: rtl/multiplexador_4to1.sv
// 4-to-1 bitwise data multiplexer with a combinational output, a registered
// copy gated by en, and a one-hot decode of the select lines.

module multiplexador_4to1_lane (
  input  logic       d0,
  input  logic       d1,
  input  logic       d2,
  input  logic       d3,
  input  logic [1:0] sel,
  output logic       y
);
  always_comb begin
    y = d0;
    case (sel)
      2'b00:   y = d0;
      2'b01:   y = d1;
      2'b10:   y = d2;
      2'b11:   y = d3;
      default: y = d0;
    endcase
  end
endmodule

module multiplexador_4to1 #(
  parameter int unsigned          WIDTH   = 1,
  parameter logic [WIDTH-1:0]     RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic             s1,
  input  logic             s0,
  input  logic             en,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_r,
  output logic             y_r_valid,
  output logic [3:0]       sel_oh
);
  logic [1:0] sel;
  assign sel = {s1, s0};

  // One single-bit mux per data bit; selection is purely bitwise.
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_lane
    multiplexador_4to1_lane u_lane (
      .d0  (d0[i]),
      .d1  (d1[i]),
      .d2  (d2[i]),
      .d3  (d3[i]),
      .sel (sel),
      .y   (y[i])
    );
  end

  always_comb begin
    sel_oh      = '0;
    sel_oh[sel] = 1'b1;
  end

  // Reset wins over en; y_r_valid marks a capture since the last reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_r       <= RST_VAL;
      y_r_valid <= 1'b0;
    end else if (en) begin
      y_r       <= y;
      y_r_valid <= 1'b1;
    end
  end
endmodule

// File: tb/tb_multiplexador_4to1.sv
// Randomized and directed checks of multiplexador_4to1 against a
// table-lookup reference model and a simple register model.
`timescale 1ns/1ps

module tb_multiplexador_4to1;
  localparam logic RST = 1'b0;

  logic       clk = 1'b0;
  logic       rst, en, s1, s0;
  logic       d0, d1, d2, d3;
  logic       y, y_r, y_r_valid;
  logic [3:0] sel_oh;

  int n_cmp = 0;
  int n_err = 0;

  logic m_yr, m_v;

  multiplexador_4to1 #(.WIDTH(1), .RST_VAL(RST)) dut (
    .clk       (clk),
    .rst       (rst),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .s1        (s1),
    .s0        (s0),
    .en        (en),
    .y         (y),
    .y_r       (y_r),
    .y_r_valid (y_r_valid),
    .sel_oh    (sel_oh)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic ref_y();
    logic d [4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    return d[2 * int'(s1) + int'(s0)];
  endfunction

  function automatic logic [3:0] ref_oh();
    return 4'(1 << (2 * int'(s1) + int'(s0)));
  endfunction

  task automatic chk_comb(input string tag);
    #1;
    chk({tag, "_y"}, 32'(y), 32'(ref_y()));
    chk({tag, "_oh"}, 32'(sel_oh), 32'(ref_oh()));
  endtask

  // Inputs are stable here; advance one edge and compare the register model.
  task automatic tick(input string tag);
    if (rst) begin
      m_yr = RST; m_v = 1'b0;
    end else if (en) begin
      m_yr = ref_y(); m_v = 1'b1;
    end
    @(posedge clk);
    #1;
    chk({tag, "_yr"}, 32'(y_r), 32'(m_yr));
    chk({tag, "_vld"}, 32'(y_r_valid), 32'(m_v));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; s1 = 1'b0; s0 = 1'b0;
    {d3, d2, d1, d0} = 4'b0000;
    m_yr = RST; m_v = 1'b0;

    // Reset state.
    @(negedge clk);
    tick("rst0");
    tick("rst1");
    chk("rst_yr_const", 32'(y_r), 32'(RST));
    chk("rst_vld_const", 32'(y_r_valid), 32'd0);
    rst = 1'b0;

    // 1. Exhaustive select x data.
    for (int s = 0; s < 4; s++)
      for (int p = 0; p < 16; p++) begin
        {s1, s0} = 2'(s);
        {d3, d2, d1, d0} = 4'(p);
        chk_comb("exh");
      end

    // 2. f = ~B.
    {d0, d1, d2, d3} = 4'b1010;
    for (int ab = 0; ab < 4; ab++) begin
      {s1, s0} = 2'(ab);
      #1;
      chk("notb", 32'(y), 32'(~ab[0] & 1'b1));
    end

    // 3. f = ~C & (A^B).
    for (int abc = 0; abc < 8; abc++) begin
      d0 = 1'b0; d3 = 1'b0;
      d1 = ~abc[0]; d2 = ~abc[0];
      s1 = abc[2]; s0 = abc[1];
      #1;
      chk("xorc", 32'(y), (abc == 2 || abc == 4) ? 32'd1 : 32'd0);
    end

    // 4. Waveform: each signal derived from elapsed time.
    for (int t = 0; t < 200; t++) begin
      d0 = 1'((t / 10) % 2);
      d1 = 1'((t / 20) % 2);
      d2 = 1'((t / 30) % 2);
      d3 = 1'((t / 40) % 2);
      s0 = 1'((t / 15) % 2);
      s1 = 1'((t / 60) % 2);
      chk_comb("wave");
    end

    // 5. Register load and hold.
    @(negedge clk);
    rst = 1'b1; en = 1'b0;
    tick("t5_rst0");
    tick("t5_rst1");
    rst = 1'b0; en = 1'b1;
    {d3, d2, d1, d0} = 4'b0100;
    {s1, s0} = 2'b10;
    tick("t5_load");
    chk("t5_load_const", 32'(y_r), 32'd1);
    chk("t5_vld_const", 32'(y_r_valid), 32'd1);
    en = 1'b0;
    {s1, s0} = 2'b01;
    tick("t5_hold");
    chk("t5_hold_const", 32'(y_r), 32'd1);

    // 6. Reset beats enable.
    rst = 1'b1; en = 1'b1;
    {s1, s0} = 2'b10;
    tick("t6");
    chk("t6_yr_const", 32'(y_r), 32'(RST));
    chk("t6_vld_const", 32'(y_r_valid), 32'd0);
    rst = 1'b0;

    // Randomized mixed traffic.
    for (int i = 0; i < 300; i++) begin
      {d3, d2, d1, d0} = 4'($urandom);
      {s1, s0} = 2'($urandom);
      en  = 1'($urandom);
      rst = ($urandom_range(0, 15) == 0);
      #1;
      chk("rnd_y", 32'(y), 32'(ref_y()));
      chk("rnd_oh", 32'(sel_oh), 32'(ref_oh()));
      tick("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
